// File: rtl/fpu_pkg.sv
// Shared FPU datapath definitions: default widths and the request/response
// records exchanged between the adder, the normaliser and the rounder.
package fpu_pkg;

  localparam int FPU_EXP_W = 10;
  localparam int FPU_EMIN  = -14;
  localparam int FPU_TAG_W = 4;

  typedef struct packed {
    logic                 sign;
    logic [FPU_EXP_W-1:0] exp;
    logic [15:0]          mant;
    logic [FPU_TAG_W-1:0] tag;
  } norm_req_t;

  typedef struct packed {
    logic                 sign;
    logic [FPU_EXP_W-1:0] exp;
    logic [15:0]          mant;
    logic [FPU_TAG_W-1:0] tag;
    logic                 zero;
    logic                 denorm;
  } norm_rsp_t;

endpackage

// File: rtl/lzc_16.sv
// Leading-zero counter for a 16-bit word. valid=0 means the word is zero and
// cnt is then meaningless (driven to 0).
module lzc_16 (
  input  logic [15:0] d,
  output logic [3:0]  cnt,
  output logic        valid
);

  logic found;

  // Scan from the MSB down; the first set bit fixes the count.
  always_comb begin
    cnt   = 4'd0;
    found = 1'b0;
    for (int i = 15; i >= 0; i--) begin
      if (!found && d[i]) begin
        cnt   = 4'(15 - i);
        found = 1'b1;
      end
    end
  end

  assign valid = |d;

endmodule

// File: rtl/fpu_norm_shift16.sv
// Post-add/sub normaliser. S1 captures the operand and its leading-zero count,
// S2 left-shifts the significand and lowers the exponent, never below EMIN.
//
// Handshake: a beat moves across an interface on the clock edge where valid
// and ready are both high. out_valid and the out_* data stay stable until
// out_ready. in_ready is combinational from pipeline state and out_ready only
// (never from in_valid). S1 may refill in the same cycle it drains into S2.
module fpu_norm_shift16
  import fpu_pkg::*;
#(
  parameter int EXP_W = FPU_EXP_W,
  parameter int EMIN  = FPU_EMIN,
  parameter int TAG_W = FPU_TAG_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sign,
  input  logic [EXP_W-1:0] in_exp,
  input  logic [15:0]      in_mant,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_sign,
  output logic [EXP_W-1:0] out_exp,
  output logic [15:0]      out_mant,
  output logic             out_zero,
  output logic             out_denorm,
  output logic [TAG_W-1:0] out_tag
);

  logic             s1_valid;
  logic             s1_sign;
  logic [EXP_W-1:0] s1_exp;
  logic [15:0]      s1_mant;
  logic [TAG_W-1:0] s1_tag;
  logic [3:0]       s1_lz;
  logic             s1_nz;

  logic       lz_cnt;
  logic [3:0] lz_val;
  logic       s1_adv;
  logic       in_fire;

  logic signed [EXP_W:0] headroom;
  logic signed [EXP_W:0] lz_ext;
  logic [3:0]            shamt;
  logic [15:0]           shifted;
  logic [EXP_W-1:0]      exp_adj;

  lzc_16 u_lzc (
    .d     (in_mant),
    .cnt   (lz_val),
    .valid (lz_cnt)
  );

  assign s1_adv   = ~out_valid | out_ready;
  assign in_ready = ~s1_valid | s1_adv;
  assign in_fire  = in_valid & in_ready;

  // Headroom above EMIN, one bit wider so the subtraction cannot wrap.
  assign headroom = $signed({s1_exp[EXP_W-1], s1_exp}) - $signed((EXP_W+1)'(EMIN));
  assign lz_ext   = $signed({{(EXP_W-3){1'b0}}, s1_lz});

  // Shift amount: full leading-zero count unless that would cross EMIN.
  always_comb begin
    shamt = 4'd0;
    if (!headroom[EXP_W]) begin
      if (headroom >= lz_ext) shamt = s1_lz;
      else                    shamt = headroom[3:0];
    end
  end

  assign shifted = s1_mant << shamt;
  assign exp_adj = s1_exp - {{(EXP_W-4){1'b0}}, shamt};

  // S1: capture the operand and its leading-zero count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_exp   <= '0;
      s1_mant  <= '0;
      s1_tag   <= '0;
      s1_lz    <= '0;
      s1_nz    <= 1'b0;
    end else if (flush) begin
      s1_valid <= 1'b0;
    end else begin
      if (in_ready) s1_valid <= in_valid;
      if (in_fire) begin
        s1_sign <= in_sign;
        s1_exp  <= in_exp;
        s1_mant <= in_mant;
        s1_tag  <= in_tag;
        s1_lz   <= lz_val;
        s1_nz   <= lz_cnt;
      end
    end
  end

  // S2: register the normalised result; held while the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_sign   <= 1'b0;
      out_exp    <= '0;
      out_mant   <= '0;
      out_zero   <= 1'b0;
      out_denorm <= 1'b0;
      out_tag    <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (s1_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_sign <= s1_sign;
        out_tag  <= s1_tag;
        if (!s1_nz) begin
          out_mant   <= '0;
          out_exp    <= '0;
          out_zero   <= 1'b1;
          out_denorm <= 1'b0;
        end else begin
          out_mant   <= shifted;
          out_exp    <= exp_adj;
          out_zero   <= 1'b0;
          out_denorm <= ~shifted[15];
        end
      end
    end
  end

endmodule

// File: tb/tb_fpu_norm_shift16.sv
// Bench for fpu_norm_shift16: directed corner cases, backpressure, flush,
// async reset, then a randomized stream against a loop-based reference model.
module tb_fpu_norm_shift16;
  import fpu_pkg::*;

  localparam int EXP_W = FPU_EXP_W;
  localparam int TAG_W = FPU_TAG_W;

  logic             clk;
  logic             rst;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic             in_sign;
  logic [EXP_W-1:0] in_exp;
  logic [15:0]      in_mant;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic             out_sign;
  logic [EXP_W-1:0] out_exp;
  logic [15:0]      out_mant;
  logic             out_zero;
  logic             out_denorm;
  logic [TAG_W-1:0] out_tag;

  int checks   = 0;
  int failures = 0;

  norm_rsp_t exp_q[$];
  bit        use_directed;
  norm_rsp_t directed_exp;

  fpu_norm_shift16 dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sign    (in_sign),
    .in_exp     (in_exp),
    .in_mant    (in_mant),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sign   (out_sign),
    .out_exp    (out_exp),
    .out_mant   (out_mant),
    .out_zero   (out_zero),
    .out_denorm (out_denorm),
    .out_tag    (out_tag)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: shift one bit at a time while the MSB is clear and the
  // exponent is still above EMIN.
  function automatic norm_rsp_t model(logic s, logic [EXP_W-1:0] e_in,
                                      logic [15:0] m_in, logic [TAG_W-1:0] t);
    norm_rsp_t   r;
    int          e;
    logic [15:0] m;
    r.sign = s;
    r.tag  = t;
    if (m_in == 16'd0) begin
      r.exp = '0; r.mant = '0; r.zero = 1'b1; r.denorm = 1'b0;
    end else begin
      e = int'($signed(e_in));
      m = m_in;
      while (!m[15] && e > FPU_EMIN) begin
        m = m << 1;
        e = e - 1;
      end
      r.exp = e[EXP_W-1:0]; r.mant = m; r.zero = 1'b0; r.denorm = ~m[15];
    end
    return r;
  endfunction

  function automatic norm_rsp_t mk(logic s, int e, logic [15:0] m,
                                   logic [TAG_W-1:0] t, logic z, logic d);
    norm_rsp_t r;
    r.sign = s; r.exp = e[EXP_W-1:0]; r.mant = m; r.tag = t; r.zero = z; r.denorm = d;
    return r;
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Driver tasks: inputs change 1 time unit after the rising edge; acceptance
  // is judged at the falling edge where everything is settled.
  task automatic step(output bit acc);
    @(negedge clk);
    acc = in_valid && in_ready && !flush && !rst;
    if (acc) exp_q.push_back(use_directed ? directed_exp
                                          : model(in_sign, in_exp, in_mant, in_tag));
    if (flush) exp_q.delete();
    @(posedge clk);
    #1;
  endtask

  task automatic gen();
    int          r;
    int          x;
    logic [15:0] m;
    in_sign = 1'($urandom_range(0, 1));
    in_tag  = 4'($urandom_range(0, 15));
    case ($urandom_range(0, 2))
      0:       x = int'($urandom_range(0, 60)) - 30;
      1:       x = int'($urandom_range(0, 8)) - 18;
      default: x = int'($urandom_range(0, 1023)) - 512;
    endcase
    in_exp = x[EXP_W-1:0];
    r = int'($urandom);
    m = r[15:0];
    in_mant = m >> $urandom_range(0, 16);
  endtask

  // Directed single beat with a hand-computed expectation and latency check.
  task automatic directed(string name, logic s, int e, logic [15:0] m,
                          logic [TAG_W-1:0] t, norm_rsp_t req);
    bit acc;
    use_directed = 1'b1;
    directed_exp = req;
    in_sign = s; in_exp = e[EXP_W-1:0]; in_mant = m; in_tag = t;
    in_valid = 1'b1;
    step(acc);
    in_valid = 1'b0;
    use_directed = 1'b0;
    check({name, "_accept"}, 64'(acc), 64'd1);
    check({name, "_lat1"}, 64'(out_valid), 64'd0);
    step(acc);
    check({name, "_lat2"}, 64'(out_valid), 64'd1);
    step(acc);
  endtask

  // Scoreboard monitor: pops the oldest expectation on every output transfer.
  always @(negedge clk) begin
    norm_rsp_t got;
    norm_rsp_t req;
    if (!rst && out_valid && out_ready) begin
      got = mk(out_sign, int'(out_exp), out_mant, out_tag, out_zero, out_denorm);
      if (exp_q.size() == 0) begin
        check("out_unexpected", 64'd1, 64'd0);
      end else begin
        req = exp_q.pop_front();
        check("rsp", 64'(got), 64'(req));
      end
    end
  end

  initial begin
    bit acc;
    int sent;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_sign = 1'b0; in_exp = '0; in_mant = '0; in_tag = '0;
    use_directed = 1'b0;
    directed_exp = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid",  64'(out_valid),  64'd0);
    check("rst_out_sign",   64'(out_sign),   64'd0);
    check("rst_out_exp",    64'(out_exp),    64'd0);
    check("rst_out_mant",   64'(out_mant),   64'd0);
    check("rst_out_zero",   64'(out_zero),   64'd0);
    check("rst_out_denorm", 64'(out_denorm), 64'd0);
    check("rst_out_tag",    64'(out_tag),    64'd0);
    rst = 1'b0;
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;

    // Corner cases
    directed("clamp_emin",  1'b0,   0, 16'h0001, 4'h1, mk(1'b0, -14, 16'h4000, 4'h1, 1'b0, 1'b1));
    directed("norm_f0",     1'b1,   5, 16'h00F0, 4'h2, mk(1'b1,  -3, 16'hF000, 4'h2, 1'b0, 1'b0));
    directed("zero",        1'b0,   7, 16'h0000, 4'hA, mk(1'b0,   0, 16'h0000, 4'hA, 1'b1, 1'b0));
    directed("below_emin",  1'b0, -20, 16'h0100, 4'h3, mk(1'b0, -20, 16'h0100, 4'h3, 1'b0, 1'b1));
    directed("already_nrm", 1'b1, -14, 16'h8001, 4'h4, mk(1'b1, -14, 16'h8001, 4'h4, 1'b0, 1'b0));
    directed("exact_fit",   1'b0,  -6, 16'h00FF, 4'h5, mk(1'b0, -14, 16'hFF00, 4'h5, 1'b0, 1'b0));

    // Backpressure: 8 beats, consumer stalls for cycles 3..6
    sent = 0;
    gen();
    for (int c = 0; c < 40 && (sent < 8 || exp_q.size() != 0); c++) begin
      out_ready = !(c >= 3 && c <= 6);
      in_valid  = (sent < 8);
      if (c == 5) begin
        check("stall_in_ready",  64'(in_ready),  64'd0);
        check("stall_out_valid", 64'(out_valid), 64'd1);
      end
      step(acc);
      if (acc) begin
        sent++;
        gen();
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    check("stream_sent", 64'(sent), 64'd8);
    check("stream_drained", 64'(exp_q.size()), 64'd0);

    // Flush with both stages full and a beat offered
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int c = 0; c < 10 && in_ready; c++) begin
      gen();
      step(acc);
    end
    check("flush_pre_full", 64'(in_ready), 64'd0);
    flush = 1'b1;
    gen();
    step(acc);
    flush = 1'b0;
    in_valid = 1'b0;
    check("flush_out_valid", 64'(out_valid), 64'd0);
    check("flush_in_ready",  64'(in_ready),  64'd1);
    out_ready = 1'b1;
    repeat (5) step(acc);

    // Async reset while stalled
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int c = 0; c < 3; c++) begin
      gen();
      step(acc);
    end
    check("rstmid_pre_valid", 64'(out_valid), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    check("rstmid_out_valid", 64'(out_valid), 64'd0);
    exp_q.delete();
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (5) step(acc);

    // Randomized traffic with random backpressure
    for (int c = 0; c < 400; c++) begin
      gen();
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 7);
      step(acc);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 20 && exp_q.size() != 0; c++) step(acc);
    check("final_drained", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
